mdio_master: RTL and testbench

// Hardware IEEE 802.3 clause-22 MDIO master for the Ethernet PHY management pins.
// It replaces software bit-banging through the framing control register: software issues one

---
 rtl/mdio_master.sv | 88 ++++++++
 tb/tb_mdio_master.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// mdio_master: clause-22 MDIO master that serialises one read/write frame per command
module mdio_master #(
  parameter int CLK_DIV = 20,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic        msoc_clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        o_edutmdc,
  output logic        o_edutmdio,
  output logic        oe_edutmdio,
  input  logic        i_edutmdio
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [5:0] TA1 = 6'(PREAMBLE_BITS + 14);
  localparam logic [5:0] TA2 = 6'(PREAMBLE_BITS + 15);
  localparam logic [5:0] LAST = 6'(PREAMBLE_BITS + 31);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_d;
  logic [DW-1:0] div;
  logic [5:0] bit_idx;
  logic phase, wr, ta_err, accept, bit_end;
  logic [63:0] frame, frame_ld;
  logic [15:0] rx;
  logic [1:0] sync;
  assign accept = state == IDLE && cmd_valid;
  assign bit_end = state == SHIFT && phase && div == DIV_MAX;
  // Frame is left-aligned so the next wire bit is always frame[63], whatever the preamble length
  assign frame_ld = {32'hFFFF_FFFF, 2'b01, cmd_write ? 2'b01 : 2'b10, cmd_phy_addr, cmd_reg_addr,
                     2'b10, cmd_write ? cmd_wdata : 16'h0} << (32 - PREAMBLE_BITS);
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign rsp_valid = state == DONE;
  assign o_edutmdc = state == SHIFT && phase;
  assign o_edutmdio = state == SHIFT && frame[63];
  assign oe_edutmdio = state == SHIFT && (wr || bit_idx < TA1);
  always_comb
    state_d = accept ? SHIFT : (bit_end && bit_idx == LAST) ? DONE : state == DONE ? IDLE : state;
  always_ff @(posedge msoc_clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge msoc_clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      bit_idx <= '0;
      phase <= 1'b0;
      wr <= 1'b0;
      ta_err <= 1'b0;
      frame <= '0;
      rx <= '0;
      sync <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      sync <= {sync[0], i_edutmdio};
      if (accept) begin
        div <= '0;
        bit_idx <= '0;
        phase <= 1'b0;
        wr <= cmd_write;
        frame <= frame_ld;
      end else if (state == SHIFT) begin
        div <= div == DIV_MAX ? '0 : div + 1'b1;
        if (div == DIV_MAX) phase <= ~phase;
        if (bit_end) begin
          if (bit_idx == TA2) ta_err <= sync[1];
          if (bit_idx > TA2) rx <= {rx[14:0], sync[1]};
          bit_idx <= bit_idx + 1'b1;
          frame <= frame << 1;
          if (bit_idx == LAST) begin
            rsp_rdata <= wr ? 16'h0 : {rx[14:0], sync[1]};
            rsp_err <= ~wr & ta_err;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: randomised and directed frames on two configurations against a frame-level model
module tb_mdio_master;
  logic clk = 0, rst = 1, sel = 0;
  logic cmd_valid = 0, cmd_write = 0, mdio_in = 1;
  logic [4:0] cmd_phy = 0, cmd_reg = 0;
  logic [15:0] cmd_wdata = 0;
  logic a_ready, a_rv, a_err, a_busy, a_mdc, a_mdio, a_oe;
  logic b_ready, b_rv, b_err, b_busy, b_mdc, b_mdio, b_oe;
  logic [15:0] a_rdata, b_rdata;
  logic phy_present = 0;
  logic [15:0] phy_data = 0;
  int n_chk = 0, n_fail = 0;
  wire s_ready = sel ? b_ready : a_ready;
  wire s_rv = sel ? b_rv : a_rv;
  wire s_err = sel ? b_err : a_err;
  wire s_busy = sel ? b_busy : a_busy;
  wire s_mdc = sel ? b_mdc : a_mdc;
  wire s_mdio = sel ? b_mdio : a_mdio;
  wire s_oe = sel ? b_oe : a_oe;
  wire [15:0] s_rdata = sel ? b_rdata : a_rdata;

  always #5 clk = ~clk;

  mdio_master #(.CLK_DIV(2), .PREAMBLE_BITS(32)) dut_a (
    .msoc_clk(clk), .rst(rst), .cmd_valid(cmd_valid & ~sel), .cmd_ready(a_ready),
    .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy), .cmd_reg_addr(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(a_rv), .rsp_rdata(a_rdata), .rsp_err(a_err), .busy(a_busy),
    .o_edutmdc(a_mdc), .o_edutmdio(a_mdio), .oe_edutmdio(a_oe), .i_edutmdio(mdio_in));

  mdio_master #(.CLK_DIV(3), .PREAMBLE_BITS(0)) dut_b (
    .msoc_clk(clk), .rst(rst), .cmd_valid(cmd_valid & sel), .cmd_ready(b_ready),
    .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy), .cmd_reg_addr(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(b_rv), .rsp_rdata(b_rdata), .rsp_err(b_err), .busy(b_busy),
    .o_edutmdc(b_mdc), .o_edutmdio(b_mdio), .oe_edutmdio(b_oe), .i_edutmdio(mdio_in));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PHY model: value the PHY puts on the wire during frame bit k (pull-up when nobody drives)
  function automatic logic phy_bit(int k, int pre);
    if (!phy_present || k == pre + 14) return 1'b1;
    if (k == pre + 15) return 1'b0;
    if (k >= pre + 16 && k < pre + 32) return phy_data[pre + 31 - k];
    return 1'b1;
  endfunction

  // Expected wire bit k of the frame (bit 0 is the first transmitted)
  function automatic logic [63:0] exp_frame(int pre, logic w, logic [4:0] p, logic [4:0] r,
                                            logic [15:0] d);
    logic [31:0] body = {2'b01, w ? 2'b01 : 2'b10, p, r, 2'b10, d};
    logic [63:0] f = '0;
    for (int k = 0; k < pre + 32; k++) f[k] = k < pre ? 1'b1 : body[31 - (k - pre)];
    return f;
  endfunction

  task automatic xact(input logic w, input logic [4:0] p, input logic [4:0] r,
                      input logic [15:0] d, input int abort_bit);
    int pre = sel ? 0 : 32;
    int cd = sel ? 3 : 2;
    int n = pre + 32;
    int lat = 1, falls = 0, nb = 0;
    logic prev = 0;
    logic [63:0] sm = '0, so = '0, em, eo = '0;
    em = exp_frame(pre, w, p, r, d);
    for (int k = 0; k < n; k++) eo[k] = w || k < pre + 14;
    @(negedge clk);
    cmd_valid = 1; cmd_write = w; cmd_phy = p; cmd_reg = r; cmd_wdata = d;
    check("ready_idle", s_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
    check("busy_after_accept", s_busy, 1);
    while (!s_rv && lat < 4000) begin
      if (prev && !s_mdc) falls++;
      if (!prev && s_mdc && nb < 64) begin
        sm[nb] = s_mdio;
        so[nb] = s_oe;
        nb++;
      end
      prev = s_mdc;
      mdio_in = phy_bit(falls, pre);
      if (abort_bit >= 0 && falls == abort_bit && s_mdc) begin
        rst = 1;
        #1;
        check("rst_mdc", s_mdc, 0);
        check("rst_mdio", s_mdio, 0);
        check("rst_oe", s_oe, 0);
        check("rst_busy", s_busy, 0);
        check("rst_rdata", s_rdata, 0);
        repeat (4) begin
          @(negedge clk);
          check("rst_no_rsp", s_rv, 0);
        end
        rst = 0;
        return;
      end
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 1 + 2 * cd * n);
    check("bit_count", nb, n);
    check("oe_pattern", so, eo);
    check("mdio_pattern", sm & eo, em & eo);
    check("rsp_rdata", s_rdata, w ? 16'h0 : phy_present ? phy_data : 16'hFFFF);
    check("rsp_err", s_err, !w && !phy_present);
    check("ready_in_done", s_ready, 0);
    @(negedge clk);
    check("rsp_one_cycle", s_rv, 0);
    check("ready_back", s_ready, 1);
    check("rdata_held", s_rdata, w ? 16'h0 : phy_present ? phy_data : 16'hFFFF);
  endtask

  initial begin
    int nrsp, r1, r2;
    logic [15:0] rd1;
    logic e1;
    repeat (3) @(negedge clk);
    check("reset_mdc", s_mdc, 0);
    check("reset_mdio", s_mdio, 0);
    check("reset_oe", s_oe, 0);
    check("reset_rv", s_rv, 0);
    check("reset_rdata", s_rdata, 0);
    check("reset_err", s_err, 0);
    check("reset_busy", s_busy, 0);
    sel = 1;
    check("reset_b_busy", s_busy, 0);
    check("reset_b_oe", s_oe, 0);
    sel = 0;
    rst = 0;
    @(negedge clk);
    check("ready_after_reset", s_ready, 1);
    xact(1'b1, 5'd1, 5'd0, 16'h1140, -1);
    phy_present = 1; phy_data = 16'h0141;
    xact(1'b0, 5'd1, 5'd2, 16'h0, -1);
    phy_present = 0;
    xact(1'b0, 5'd1, 5'd2, 16'h0, -1);
    phy_present = 1; phy_data = 16'hA5C3;
    xact(1'b0, 5'd7, 5'd3, 16'h0, 20);
    xact(1'b1, 5'd2, 5'd4, 16'h8001, -1);
    repeat (4) begin
      phy_present = 1'($urandom);
      phy_data = 16'($urandom);
      xact(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), -1);
    end
    phy_present = 0; mdio_in = 1;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_phy = 5'd3; cmd_reg = 5'd1;
    @(negedge clk);
    cmd_write = 1; cmd_phy = 5'd5; cmd_reg = 5'd9; cmd_wdata = 16'hBEEF;
    nrsp = 0; r1 = 0; r2 = 0; rd1 = 0; e1 = 0;
    for (int c = 1; c < 700; c++) begin
      if (s_rv) begin
        nrsp++;
        if (nrsp == 1) begin
          r1 = c; rd1 = s_rdata; e1 = s_err;
        end else r2 = c;
      end
      if (r1 > 0 && c == r1 + 1) check("second_accept_ready", s_ready, 1);
      if (r1 > 0 && c == r1 + 2) check("second_busy", s_busy, 1);
      if (r1 > 0 && c > r1 + 1) cmd_valid = s_busy && (c % 5 == 0);
      @(negedge clk);
    end
    cmd_valid = 0;
    check("two_cmd_rsp_count", nrsp, 2);
    check("two_cmd_first_rsp", r1, 257);
    check("two_cmd_second_rsp", r2, 515);
    check("two_cmd_first_rdata", rd1, 16'hFFFF);
    check("two_cmd_first_err", e1, 1);
    check("two_cmd_second_rdata", s_rdata, 0);
    check("two_cmd_second_err", s_err, 0);
    sel = 1;
    xact(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), -1);
    phy_present = 1; phy_data = 16'($urandom);
    xact(1'b0, 5'($urandom), 5'($urandom), 16'h0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
